// File: rtl/cache_arbiter.sv
// Arbitrates whole-line requests from the L1 I-cache and D-cache onto one shared memory port.
// The winning request is latched for the whole transaction; ties alternate between the two caches.
module cache_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

    state_t            state;
    logic [ADDR_W-1:0] req_addr;
    logic [LINE_W-1:0] req_wdata;
    logic              req_is_write;
    logic              last_grant;
    logic              d_req;
    logic              grant_d;
    logic              busy;

    assign d_req = d_read | d_write;
    // On a tie the side that did not win last goes first; last_grant resets to I, so D wins the first tie.
    assign grant_d = d_req & (~i_read | ~last_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            req_addr     <= '0;
            req_wdata    <= '0;
            req_is_write <= 1'b0;
            last_grant   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state        <= SERVE_D;
                        req_addr     <= d_address;
                        req_wdata    <= d_wdata;
                        req_is_write <= d_write;
                        last_grant   <= 1'b1;
                    end else if (i_read) begin
                        state        <= SERVE_I;
                        req_addr     <= i_address;
                        req_is_write <= 1'b0;
                        last_grant   <= 1'b0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (mem_resp) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Command lines decode only from registers, so they stay steady until mem_resp.
    assign busy        = (state != IDLE);
    assign mem_read    = busy & ~req_is_write;
    assign mem_write   = busy & req_is_write;
    assign mem_address = req_addr;
    assign mem_wdata   = req_wdata;

    assign i_resp  = mem_resp & (state == SERVE_I);
    assign d_resp  = mem_resp & (state == SERVE_D);
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(d_read && d_write))
                else $warning("cache_arbiter: d_read and d_write asserted together, serving as write");
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: transaction-level grant-order model, latency-programmable
// memory responder and a shadow memory for returned line contents.
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read;
    logic [31:0]  i_address;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata;
    logic         mem_resp;
    logic         mem_resp_m = 1'b0;
    logic         spur = 1'b0;

    assign mem_resp = mem_resp_m | spur;

    cache_arbiter #(.ADDR_W(32), .LINE_W(256)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]  addr;
        logic         wr;
        logic [255:0] wdata;
        int           start;
        int           resp;
    } cmd_t;

    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    int           mem_lat = 3;
    int           cnt = 0;
    int           exp_last = 0;
    cmd_t         log_q[$];
    logic [255:0] mem_arr[logic [31:0]];
    logic [255:0] shadow[logic [31:0]];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] dflt(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_F00D}};
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [31:0] rand_ia();
        return 32'($urandom_range(0, 63)) << 5;
    endfunction

    function automatic logic [31:0] rand_da();
        return 32'h1000 + (32'($urandom_range(0, 63)) << 5);
    endfunction

    // Memory responder: answers mem_lat cycles after a command appears, logs every command.
    always @(posedge clk) begin
        #2;
        if (rst) begin
            cnt = 0;
            mem_resp_m = 1'b0;
        end else if (mem_resp_m) begin
            mem_resp_m = 1'b0;
            cnt = 0;
        end else if (mem_read || mem_write) begin
            cnt++;
            checki("cmd_onehot", int'(mem_read) + int'(mem_write), 1);
            if (cnt == 1) begin
                log_q.push_back('{addr: mem_address, wr: mem_write, wdata: mem_wdata, start: cyc, resp: -1});
            end else if (log_q.size() > 0) begin
                checki("cmd_addr_steady", int'(mem_address), int'(log_q[log_q.size()-1].addr));
                checki("cmd_wr_steady", int'(mem_write), int'(log_q[log_q.size()-1].wr));
                check("cmd_wdata_steady", mem_wdata, log_q[log_q.size()-1].wdata);
            end
            if (cnt >= mem_lat) begin
                if (mem_write) mem_arr[mem_address] = mem_wdata;
                else mem_rdata = mem_arr.exists(mem_address) ? mem_arr[mem_address] : dflt(mem_address);
                if (log_q.size() > 0) log_q[log_q.size()-1].resp = cyc;
                mem_resp_m = 1'b1;
            end
        end
    end

    task automatic drive_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input logic [31:0] a, input logic [255:0] w, input logic wr, input bit ill);
        d_address = a;
        d_wdata   = w;
        d_write   = wr;
        d_read    = !wr || ill;
    endtask

    // ni I-reads and nd D-transactions; each side re-requests right after its resp while it has work.
    task automatic run(input int ni, input int nd, input int lat, input int dmode, input bit illegal,
                       input bit chg, input logic [31:0] ia0, input logic [31:0] da0, input logic [255:0] wd0);
        logic [31:0]  ia_q[$];
        logic [31:0]  da_q[$];
        logic [255:0] wd_q[$];
        logic         dw_q[$];
        int           side_q[$];
        int           pi, pd, last, t0, budget, n_ir, n_dr, n, s;
        bit           gi, gd;
        for (int k = 0; k < ni; k++) ia_q.push_back(k == 0 ? ia0 : rand_ia());
        for (int k = 0; k < nd; k++) begin
            da_q.push_back(k == 0 ? da0 : rand_da());
            wd_q.push_back(k == 0 ? wd0 : rand_line());
            dw_q.push_back(dmode == 1 ? 1'b0 : dmode == 2 ? 1'b1 : 1'($urandom_range(0, 1)));
        end
        pi = ni; pd = nd; last = exp_last;
        while (pi > 0 || pd > 0) begin
            if (pi > 0 && pd > 0) s = 1 - last;
            else if (pd > 0) s = 1;
            else s = 0;
            side_q.push_back(s);
            if (s == 1) pd--; else pi--;
            last = s;
        end

        drive_wait();
        mem_lat = lat;
        log_q.delete();
        t0 = cyc;
        if (ni > 0) begin i_read = 1'b1; i_address = ia_q[0]; end
        if (nd > 0) drive_d(da_q[0], wd_q[0], dw_q[0], illegal);
        n_ir = 0; n_dr = 0;
        budget = (ni + nd) * (lat + 3) + 10;
        while ((n_ir < ni || n_dr < nd) && budget > 0) begin
            @(negedge clk);
            budget--;
            gi = i_resp; gd = d_resp;
            if (gi) begin
                if (n_ir < ni) check("i_rdata", i_rdata, dflt(ia_q[n_ir]));
                n_ir++;
            end
            if (gd) begin
                if (n_dr < nd) begin
                    if (!dw_q[n_dr])
                        check("d_rdata", d_rdata,
                              shadow.exists(da_q[n_dr]) ? shadow[da_q[n_dr]] : dflt(da_q[n_dr]));
                    else
                        shadow[da_q[n_dr]] = wd_q[n_dr];
                end
                n_dr++;
            end
            drive_wait();
            if (gi) begin
                if (n_ir < ni) i_address = ia_q[n_ir];
                else i_read = 1'b0;
            end
            if (gd) begin
                if (n_dr < nd) drive_d(da_q[n_dr], wd_q[n_dr], dw_q[n_dr], illegal);
                else begin d_read = 1'b0; d_write = 1'b0; end
            end
            if (chg && n_dr < nd && log_q.size() > 0) d_wdata = ~d_wdata;
        end
        checki("run_in_budget", int'(budget > 0), 1);
        repeat (2) begin
            @(negedge clk);
            if (i_resp) n_ir++;
            if (d_resp) n_dr++;
        end
        checki("i_resp_count", n_ir, ni);
        checki("d_resp_count", n_dr, nd);
        checki("cmd_count", log_q.size(), ni + nd);

        n = (log_q.size() < side_q.size()) ? log_q.size() : side_q.size();
        pi = 0; pd = 0;
        for (int k = 0; k < n; k++) begin
            if (side_q[k] == 1) begin
                checki("grant_addr_d", int'(log_q[k].addr), int'(da_q[pd]));
                checki("grant_wr_d", int'(log_q[k].wr), int'(dw_q[pd]));
                if (dw_q[pd]) check("grant_wdata_d", log_q[k].wdata, wd_q[pd]);
                pd++;
            end else begin
                checki("grant_addr_i", int'(log_q[k].addr), int'(ia_q[pi]));
                checki("grant_wr_i", int'(log_q[k].wr), 0);
                pi++;
            end
            checki("cmd_duration", log_q[k].resp - log_q[k].start + 1, lat);
            if (k == 0) checki("grant_latency", log_q[k].start, t0 + 1);
            else checki("b2b_gap", log_q[k].start, log_q[k-1].resp + 2);
        end
        if (side_q.size() > 0) exp_last = side_q[side_q.size()-1];
    endtask

    initial begin
        int w;
        rst = 1'b1;
        i_read = 1'b0; i_address = '0;
        d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
        mem_rdata = {8{32'hDEADBEEF}};
        repeat (3) drive_wait();
        @(negedge clk);
        checki("rst_mem_read", int'(mem_read), 0);
        checki("rst_mem_write", int'(mem_write), 0);
        checki("rst_mem_address", int'(mem_address), 0);
        check("rst_mem_wdata", mem_wdata, '0);
        checki("rst_i_resp", int'(i_resp), 0);
        checki("rst_d_resp", int'(d_resp), 0);
        check("rst_i_rdata_fwd", i_rdata, {8{32'hDEADBEEF}});
        check("rst_d_rdata_fwd", d_rdata, {8{32'hDEADBEEF}});
        drive_wait();
        rst = 1'b0;
        exp_last = 0;

        // Tie straight after reset: D first, then I.
        run(1, 1, 2, 1, 1'b0, 1'b0, 32'h0000_0020, 32'h0000_1020, '0);
        // I-only read, latency 3.
        run(1, 0, 3, 0, 1'b0, 1'b0, 32'h0000_0060, '0, '0);
        // Continuous contention, 4 transactions per side.
        run(4, 4, 2, 0, 1'b0, 1'b0, rand_ia(), rand_da(), rand_line());
        // D write-back with d_wdata disturbed after the grant, then read it back.
        run(0, 1, 3, 2, 1'b0, 1'b1, '0, 32'h0000_1000, {32{8'hA5}});
        run(0, 1, 2, 1, 1'b0, 1'b0, '0, 32'h0000_1000, '0);
        // d_read and d_write together: served as a write.
        run(0, 1, 2, 2, 1'b1, 1'b0, '0, 32'h0000_1100, rand_line());
        run(0, 1, 1, 1, 1'b0, 1'b0, '0, 32'h0000_1100, '0);

        // Spurious mem_resp while idle.
        drive_wait();
        spur = 1'b1;
        @(negedge clk);
        checki("spur_i_resp", int'(i_resp), 0);
        checki("spur_d_resp", int'(d_resp), 0);
        checki("spur_mem_read", int'(mem_read), 0);
        checki("spur_mem_write", int'(mem_write), 0);
        drive_wait();
        spur = 1'b0;
        run(1, 0, 2, 0, 1'b0, 1'b0, 32'h0000_0100, '0, '0);

        // Reset in the middle of a D read.
        drive_wait();
        mem_lat = 6;
        d_read = 1'b1; d_address = 32'h0000_1040;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!mem_read && w < 5);
        checki("rstmid_cmd_up", int'(mem_read), 1);
        drive_wait();
        rst = 1'b1;
        @(negedge clk);
        checki("rstmid_no_dresp", int'(d_resp), 0);
        drive_wait();
        rst = 1'b0;
        d_read = 1'b0;
        @(negedge clk);
        checki("rstmid_mem_read", int'(mem_read), 0);
        checki("rstmid_mem_write", int'(mem_write), 0);
        checki("rstmid_d_resp", int'(d_resp), 0);
        checki("rstmid_mem_address", int'(mem_address), 0);
        exp_last = 0;
        run(1, 0, 2, 0, 1'b0, 1'b0, 32'h0000_0140, '0, '0);

        // Randomised rounds.
        for (int r = 0; r < 12; r++) begin
            int ni, nd;
            ni = $urandom_range(0, 2);
            nd = $urandom_range(0, 2);
            if (ni == 0 && nd == 0) ni = 1;
            run(ni, nd, $urandom_range(1, 4), 0, 1'b0, 1'b0, rand_ia(), rand_da(), rand_line());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port-to-one memory arbiter between the L1 instruction cache and L1 data cache of the pipelined RV32I core and the single shared physical-memory (or L2) line port. It accepts whole-line read requests from the I-cache and whole-line read/write requests from the D-cache, grants one at a time, latches the winning request, and routes the response back to that requester only. Tied requests are granted round-robin, so neither cache can starve the other.

## Interface
- ADDR_W, 32, line address width (byte address, line-aligned by the caches)
- LINE_W, 256, cache line width in bits
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_read  in  1  I-cache line read request, held until i_resp
- i_address  in  ADDR_W  I-cache request address
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request, held until d_resp
- d_write  in  1  D-cache line write-back request, held until d_resp
- d_address  in  ADDR_W  D-cache request address
- d_wdata  in  LINE_W  D-cache write-back line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  read command to shared memory port
- mem_write  out  1  write command to shared memory port
- mem_address  out  ADDR_W  latched request address
- mem_wdata  out  LINE_W  latched write line
- mem_rdata  in  LINE_W  read line from memory
- mem_resp  in  1  memory completion pulse

## Operation
- States: IDLE, SERVE_I, SERVE_D. Reset state IDLE.
- Registers: req_addr, req_wdata, req_is_write, last_grant (0 = I, 1 = D). Reset values: all zero, last_grant = I.
- IDLE:
  - Only I requests: go to SERVE_I, latch i_address, req_is_write = 0.
  - Only D requests: go to SERVE_D, latch d_address and d_wdata, req_is_write = d_write.
  - Both request: grant the side not equal to last_grant. After reset the first tie goes to D.
  - On every grant, last_grant is updated to the granted side.
- SERVE_x:
  - mem_read = ~req_is_write and mem_write = req_is_write, both held steady until mem_resp.
  - mem_address and mem_wdata are driven from the latched registers. Changes on the cache inputs after the grant are ignored.
  - On mem_resp: pulse x_resp the same cycle, then return to IDLE on the next edge.
- Response routing:
  - i_resp = mem_resp & (state == SERVE_I).
  - d_resp = mem_resp & (state == SERVE_D).
  - i_rdata and d_rdata both forward mem_rdata combinationally. Data is valid only with the matching resp.
- d_read and d_write asserted together is illegal. The write takes precedence, and a simulation assertion fires.
- mem_resp in IDLE is ignored: no resp is emitted and the state does not change.
- Reset mid-transaction:
  - State goes to IDLE and mem_read/mem_write are low from the next edge.
  - The in-flight transaction is abandoned. The memory model must be reset in the same cycle.

## Timing
- Reset values of outputs: mem_read = 0, mem_write = 0, mem_address = 0, mem_wdata = 0, i_resp = 0, d_resp = 0. rdata outputs follow mem_rdata.
- Arbitration latency: a request sampled in IDLE at edge t puts its command on the mem port from cycle t+1.
- Total latency: 1 + N cycles, where N is the memory latency from command to mem_resp.
- Back-to-back:
  - After a resp at cycle c, the arbiter is in IDLE at c+1 and can grant at the c+1 edge. The next command appears at c+2.
  - A requester must drop its request at c+1 unless it is issuing a new request.
- Command signals never glitch or change while mem_resp is pending.

## Test plan
- I-only read: i_read=1, i_address=0x0000_0060, memory latency 3 -> mem_read high for 3 cycles with mem_address=0x60; i_resp pulses once with i_rdata = memory line; d_resp stays 0.
- D write-back: d_write=1, d_address=0x0000_1000, d_wdata=0xA5 repeated -> mem_write=1 with latched data. Changing d_wdata mid-transaction does not alter mem_wdata. d_resp pulses once.
- Tie after reset: i_read and d_read rise in the same cycle -> D is served first, then I, with one idle cycle between the two commands. A second tie is served I first.
- Continuous contention: both sides re-request immediately for 8 transactions -> grants alternate D, I, D, I…; each side gets 4 grants.
- Reset mid-transaction: rst=1 during SERVE_D before mem_resp -> next cycle mem_read=mem_write=0, state IDLE, no d_resp. After reset, a fresh I request is served normally.
- Spurious mem_resp in IDLE -> no i_resp/d_resp, no state change. d_read and d_write asserted together -> a write is issued and the assertion is flagged.
